id_ex_pipe_reg: RTL

Parametrised ID/EX pipeline register, the successor to the fixed-width ID/EX latch. It carries decode control and operand payload from ID to EX with a valid/ready handshake and a 2-entry skid buffer, so EX back-pressure never reaches ID combinationally. It adds synchronous flush (bubble insertion), side-effect gating on invalid slots and a saturating stall-cycle counter. Sits between the decoder/operand muxes and the ALU/data-memory stage.

---
 rtl/id_ex_pipe_reg.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake and 2-entry skid.
// Ports: clk/rst_n, id_* payload+handshake in, flush, ex_* payload+handshake out, stall_cnt.
module id_ex_pipe_reg #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 16,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic                id_ret_enable,
  input  logic [1:0]          id_rf_d_sel,
  input  logic                id_dm_we,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_dm_addr_sel,
  input  logic [IMM_W-1:0]    id_immediate,
  input  logic [DATA_W-1:0]   id_muxa,
  input  logic [DATA_W-1:0]   id_muxb,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic                ex_ret_enable,
  output logic [1:0]          ex_rf_d_sel,
  output logic                ex_dm_we,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_dm_addr_sel,
  output logic [IMM_W-1:0]    ex_immediate,
  output logic [DATA_W-1:0]   ex_muxa,
  output logic [DATA_W-1:0]   ex_muxb,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int P = 5 + ALU_OP_W + IMM_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [P-1:0]   main_q;
  logic [P-1:0]   skid_q;
  logic [P-1:0]   id_pay;
  logic           main_valid;
  logic           skid_valid;
  logic           accept;
  logic           pop;
  logic           load_main;
  logic           load_skid;
  logic           skid_to_main;
  logic           ret_raw;
  logic           dm_we_raw;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign id_ready   = !skid_valid;
  assign ex_valid   = main_valid;
  assign accept     = id_valid && id_ready;
  assign pop        = main_valid && ex_ready;

  assign id_pay = {id_ret_enable, id_rf_d_sel, id_dm_we,
                   id_alu_op, id_dm_addr_sel, id_immediate,
                   id_muxa, id_muxb};

  assign {ret_raw, ex_rf_d_sel, dm_we_raw,
          ex_alu_op, ex_dm_addr_sel, ex_immediate,
          ex_muxa, ex_muxb} = main_q;

  // Side effects must not fire from a stale slot.
  assign ex_ret_enable = ret_raw & main_valid;
  assign ex_dm_we      = dm_we_raw & main_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      ONE: begin
        unique case (1'b1)
          accept && pop: load_main = 1'b1;
          accept && !pop: begin
            load_skid = 1'b1;
            state_d   = FULL;
          end
          !accept && pop: state_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          skid_to_main = 1'b1;
          state_d      = ONE;
        end
      end
      default: begin
        // Covers EMPTY and the unreachable 01 encoding.
        state_d = EMPTY;
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= id_pay;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= id_pay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !ex_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
